// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch/execute handshake and PC-update bus between the sequencer and its datapath.
interface pc_sequencer_if;
    logic [31:0] pc_cur;
    logic        imem_ack;
    logic        instr_done;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        exc_req;
    logic        halt;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ir_load;
    logic [31:0] epc;
    logic [2:0]  state_o;

    modport master (
        input  pc_cur, imem_ack, instr_done, stall, br_taken, br_target,
               jmp_valid, jmp_target, exc_req, halt,
        output pc_ena, pc_next, imem_req, imem_addr, ir_load, epc, state_o
    );

    modport slave (
        output pc_cur, imem_ack, instr_done, stall, br_taken, br_target,
               jmp_valid, jmp_target, exc_req, halt,
        input  pc_ena, pc_next, imem_req, imem_addr, ir_load, epc, state_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute/update control FSM choosing the next PC with exception > jump > branch > sequential priority.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h00400000,
    parameter logic [31:0] EXC_VEC   = 32'h00400004
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, HALT} state_t;

    state_t      state, state_nx;
    logic        exc_pend, jmp_pend, br_pend, halt_pend;
    logic [31:0] jmp_tgt, br_tgt, epc_q, sel_pc;
    logic        in_fetch, in_exec, in_update, aligned, fetch_ok, misalign;

    assign in_fetch  = state == FETCH;
    assign in_exec   = state == EXEC;
    assign in_update = state == UPDATE;
    assign aligned   = bus.pc_cur[1:0] == 2'b00;
    assign fetch_ok  = in_fetch && aligned;
    assign misalign  = in_fetch && !aligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Redirect requests accumulate until the single UPDATE cycle consumes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_pend  <= 1'b0;
            jmp_pend  <= 1'b0;
            br_pend   <= 1'b0;
            halt_pend <= 1'b0;
            jmp_tgt   <= '0;
            br_tgt    <= '0;
            epc_q     <= '0;
        end else if (in_update) begin
            if (exc_pend) epc_q <= bus.pc_cur;
            exc_pend  <= 1'b0;
            jmp_pend  <= 1'b0;
            br_pend   <= 1'b0;
            halt_pend <= 1'b0;
            jmp_tgt   <= '0;
            br_tgt    <= '0;
        end else begin
            if (misalign || ((in_fetch || in_exec) && bus.exc_req)) exc_pend <= 1'b1;
            if (in_exec && bus.jmp_valid) begin
                jmp_pend <= 1'b1;
                jmp_tgt  <= bus.jmp_target;
            end
            if (in_exec && bus.br_taken) begin
                br_pend <= 1'b1;
                br_tgt  <= bus.br_target;
            end
            if (in_exec && bus.halt) halt_pend <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = FETCH;
            FETCH:   state_nx = misalign ? UPDATE : (bus.imem_ack ? EXEC : FETCH);
            EXEC:    state_nx = (bus.instr_done && !bus.stall) ? UPDATE : EXEC;
            UPDATE:  state_nx = halt_pend ? HALT : FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
        sel_pc        = exc_pend ? EXC_VEC : jmp_pend ? jmp_tgt : br_pend ? br_tgt : bus.pc_cur + 32'd4;
        bus.pc_ena    = in_update;
        bus.pc_next   = (state == IDLE) ? RESET_VEC : in_update ? sel_pc : bus.pc_cur;
        bus.imem_req  = fetch_ok;
        bus.imem_addr = fetch_ok ? bus.pc_cur : '0;
        bus.ir_load   = fetch_ok && bus.imem_ack;
        bus.epc       = epc_q;
        bus.state_o   = state;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scenario tasks drive the sequencer; expected PC updates queue up and are matched against each pc_ena pulse.
module tb_pc_sequencer;
    localparam logic [31:0] RESET_VEC = 32'h00400000;
    localparam logic [31:0] EXC_VEC   = 32'h00400004;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    logic [31:0] sb[$];

    pc_sequencer_if pif ();

    pc_sequencer #(.RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(pif)
    );

    always #5 clk = ~clk;

    // Every pc_ena pulse must match the oldest queued expectation; pulses with nothing queued are errors.
    always @(negedge clk) begin
        if (pif.pc_ena === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pc_ena: got pc_next %h with no update expected", pif.pc_next);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (pif.pc_next !== exp) begin
                    errors++;
                    $display("FAIL pc_next: got %h expected %h", pif.pc_next, exp);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch_to_exec(input logic [31:0] pc);
        pif.pc_cur   = pc;
        pif.imem_ack = 1'b1;
        step();
        pif.imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (pif.state_o !== 3'd0 || pif.pc_next !== RESET_VEC || pif.pc_ena !== 1'b0 ||
            pif.imem_req !== 1'b0 || pif.ir_load !== 1'b0 || pif.imem_addr !== 32'h0 || pif.epc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got state %0d pc_next %h ena %b req %b ir %b addr %h epc %h expected 0 %h 0 0 0 0 0",
                     pif.state_o, pif.pc_next, pif.pc_ena, pif.imem_req, pif.ir_load, pif.imem_addr, pif.epc, RESET_VEC);
        end
        step(2);
        vectors++;
        if (pif.state_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold: got state %0d expected 0", pif.state_o);
        end
        rst = 1'b1;
        pif.pc_cur = 32'h00400000;
        vectors++;
        if (pif.state_o !== 3'd0 || pif.pc_next !== RESET_VEC) begin
            errors++;
            $display("FAIL idle_after_release: got state %0d pc_next %h expected 0 %h", pif.state_o, pif.pc_next, RESET_VEC);
        end
        step();
        vectors++;
        if (pif.state_o !== 3'd1 || pif.imem_req !== 1'b1 || pif.imem_addr !== 32'h00400000) begin
            errors++;
            $display("FAIL first_fetch: got state %0d req %b addr %h expected 1 1 00400000", pif.state_o, pif.imem_req, pif.imem_addr);
        end
    endtask

    task automatic test_sequential();
        step(2);
        vectors++;
        if (pif.state_o !== 3'd1 || pif.imem_req !== 1'b1 || pif.ir_load !== 1'b0 || pif.pc_next !== 32'h00400000) begin
            errors++;
            $display("FAIL fetch_wait: got state %0d req %b ir %b pc_next %h expected 1 1 0 00400000",
                     pif.state_o, pif.imem_req, pif.ir_load, pif.pc_next);
        end
        pif.imem_ack = 1'b1;
        #1;
        vectors++;
        if (pif.ir_load !== 1'b1) begin
            errors++;
            $display("FAIL ir_load: got %b expected 1", pif.ir_load);
        end
        step();
        pif.imem_ack = 1'b0;
        vectors++;
        if (pif.state_o !== 3'd2 || pif.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL exec_entry: got state %0d req %b expected 2 0", pif.state_o, pif.imem_req);
        end
        step(2);
        pif.instr_done = 1'b1;
        sb.push_back(32'h00400004);
        step();
        pif.instr_done = 1'b0;
        vectors++;
        if (pif.state_o !== 3'd3) begin
            errors++;
            $display("FAIL seq_update: got state %0d expected 3", pif.state_o);
        end
        step();
        vectors++;
        if (pif.state_o !== 3'd1 || pif.pc_ena !== 1'b0) begin
            errors++;
            $display("FAIL seq_refetch: got state %0d ena %b expected 1 0", pif.state_o, pif.pc_ena);
        end
    endtask

    task automatic test_priority();
        fetch_to_exec(32'h00400010);
        pif.br_taken = 1'b1; pif.br_target = 32'h00400100;
        step();
        pif.br_taken = 1'b0; pif.jmp_valid = 1'b1; pif.jmp_target = 32'h00400200;
        step();
        pif.jmp_valid = 1'b0; pif.exc_req = 1'b1;
        step();
        pif.exc_req = 1'b0; pif.instr_done = 1'b1;
        sb.push_back(EXC_VEC);
        step();
        pif.instr_done = 1'b0;
        step();
        vectors++;
        if (pif.epc !== 32'h00400010 || pif.state_o !== 3'd1) begin
            errors++;
            $display("FAIL exc_epc: got epc %h state %0d expected 00400010 1", pif.epc, pif.state_o);
        end
    endtask

    task automatic test_redirects();
        fetch_to_exec(32'h00400020);
        pif.br_taken = 1'b1; pif.br_target = 32'h00400100;
        step();
        pif.br_target = 32'h00400180; pif.instr_done = 1'b1;
        sb.push_back(32'h00400180);
        step();
        pif.br_taken = 1'b0; pif.instr_done = 1'b0;
        step();
        fetch_to_exec(32'h00400180);
        pif.br_taken = 1'b1; pif.br_target = 32'h00400300;
        step();
        pif.br_taken = 1'b0; pif.jmp_valid = 1'b1; pif.jmp_target = 32'h00400400; pif.instr_done = 1'b1;
        sb.push_back(32'h00400400);
        step();
        pif.jmp_valid = 1'b0; pif.instr_done = 1'b0;
        step();
        vectors++;
        if (pif.epc !== 32'h00400010) begin
            errors++;
            $display("FAIL epc_hold: got %h expected 00400010", pif.epc);
        end
    endtask

    task automatic test_misaligned();
        pif.pc_cur = 32'h00400002;
        pif.imem_ack = 1'b1;
        #1;
        vectors++;
        if (pif.imem_req !== 1'b0 || pif.ir_load !== 1'b0 || pif.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL misalign_req: got req %b ir %b addr %h expected 0 0 0", pif.imem_req, pif.ir_load, pif.imem_addr);
        end
        sb.push_back(EXC_VEC);
        step();
        pif.imem_ack = 1'b0;
        vectors++;
        if (pif.state_o !== 3'd3) begin
            errors++;
            $display("FAIL misalign_update: got state %0d expected 3", pif.state_o);
        end
        step();
        pif.pc_cur = 32'h00400004;
        vectors++;
        if (pif.epc !== 32'h00400002 || pif.state_o !== 3'd1) begin
            errors++;
            $display("FAIL misalign_epc: got epc %h state %0d expected 00400002 1", pif.epc, pif.state_o);
        end
    endtask

    task automatic test_stall_wrap();
        fetch_to_exec(32'hFFFFFFFC);
        pif.instr_done = 1'b1; pif.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (pif.state_o !== 3'd2 || pif.pc_ena !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got state %0d ena %b expected 2 0", i, pif.state_o, pif.pc_ena);
            end
        end
        pif.stall = 1'b0;
        sb.push_back(32'h00000000);
        step();
        pif.instr_done = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pc;
            pc = 32'h00401000 + 32'(i) * 32'd8;
            fetch_to_exec(pc);
            pif.instr_done = 1'b1;
            sb.push_back(pc + 32'd4);
            step();
            pif.instr_done = 1'b0;
            pif.br_taken = 1'b1; pif.br_target = 32'h00409000; pif.halt = 1'b1; pif.exc_req = 1'b1;
            step();
            pif.br_taken = 1'b0; pif.halt = 1'b0; pif.exc_req = 1'b0;
            vectors++;
            if (pif.state_o !== 3'd1) begin
                errors++;
                $display("FAIL b2b_state: instr %0d got state %0d expected 1", i, pif.state_o);
            end
        end
    endtask

    task automatic test_halt();
        fetch_to_exec(32'h00402000);
        pif.halt = 1'b1;
        step();
        pif.halt = 1'b0; pif.instr_done = 1'b1;
        sb.push_back(32'h00402004);
        step();
        pif.instr_done = 1'b0;
        step();
        pif.imem_ack = 1'b1; pif.instr_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (pif.state_o !== 3'd4 || pif.pc_ena !== 1'b0 || pif.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_sticky: cycle %0d got state %0d ena %b req %b expected 4 0 0", i, pif.state_o, pif.pc_ena, pif.imem_req);
            end
            step();
        end
        pif.imem_ack = 1'b0; pif.instr_done = 1'b0;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (pif.state_o !== 3'd0 || pif.epc !== 32'h0) begin
            errors++;
            $display("FAIL halt_reset: got state %0d epc %h expected 0 0", pif.state_o, pif.epc);
        end
    endtask

    task automatic test_reset_mid_exec();
        rst = 1'b1;
        step();
        fetch_to_exec(32'h00403000);
        pif.br_taken = 1'b1; pif.br_target = 32'h00409990;
        step();
        pif.br_taken = 1'b0;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (pif.state_o !== 3'd0 || pif.pc_next !== RESET_VEC || pif.pc_ena !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_exec: got state %0d pc_next %h ena %b expected 0 %h 0", pif.state_o, pif.pc_next, pif.pc_ena, RESET_VEC);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (pif.state_o !== 3'd1) begin
            errors++;
            $display("FAIL restart_fetch: got state %0d expected 1", pif.state_o);
        end
        fetch_to_exec(32'h00403000);
        pif.instr_done = 1'b1;
        sb.push_back(32'h00403004);
        step();
        pif.instr_done = 1'b0;
        step();
    endtask

    initial begin
        pif.pc_cur = '0; pif.imem_ack = 1'b0; pif.instr_done = 1'b0; pif.stall = 1'b0;
        pif.br_taken = 1'b0; pif.br_target = '0; pif.jmp_valid = 1'b0; pif.jmp_target = '0;
        pif.exc_req = 1'b0; pif.halt = 1'b0;
        test_reset();
        test_sequential();
        test_priority();
        test_redirects();
        test_misaligned();
        test_stall_wrap();
        test_back_to_back();
        test_halt();
        test_reset_mid_exec();
        step(2);
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_updates: got %0d outstanding expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h00400000, PC value presented while in IDLE.
REQ-002 SHALL have parameter EXC_VEC, default 32'h00400004, exception redirect target.
REQ-003 SHALL have port clk  in  1  single clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port pc_cur  in  32  current PC register value.
REQ-006 SHALL have port imem_ack  in  1  instruction memory fetch complete.
REQ-007 SHALL have port instr_done  in  1  current instruction finished executing.
REQ-008 SHALL have port stall  in  1  hold in EXEC.
REQ-009 SHALL have ports br_taken/br_target  in  1/32  taken branch and its target.
REQ-010 SHALL have ports jmp_valid/jmp_target  in  1/32  jump and its target.
REQ-011 SHALL have ports exc_req  in  1  exception request; halt  in  1  stop after current instruction.
REQ-012 SHALL have ports pc_ena/pc_next  out  1/32  PC register write enable and data.
REQ-013 SHALL have ports imem_req/imem_addr  out  1/32  fetch request and address.
REQ-014 SHALL have ports ir_load  out  1  load instruction register; epc  out  32  faulting PC; state_o  out  3  FSM state.

Function
REQ-015 SHALL encode states IDLE=0, FETCH=1, EXEC=2, UPDATE=3, HALT=4 on state_o.
REQ-016 SHALL go IDLE->FETCH on the first rising edge after rst deasserts.
REQ-017 FETCH, pc_cur[1:0]==0: imem_req=1, imem_addr=pc_cur until imem_ack; ir_load=imem_ack (same cycle, combinational); on ack -> EXEC.
REQ-018 FETCH, pc_cur[1:0]!=0: imem_req=0, ir_load=0, exc_pend set, -> UPDATE next edge (misalignment exception).
REQ-019 EXEC: -> UPDATE on edge where instr_done=1 and stall=0; otherwise stay; stall with instr_done=1 holds indefinitely.
REQ-020 Redirect latches SHALL sample in EXEC only (exc_req also in FETCH): exc_pend; jmp_pend+jmp_tgt; br_pend+br_tgt; repeated same-type assertion overwrites target (last wins).
REQ-021 Requests asserted on the EXEC->UPDATE edge itself SHALL be included in the UPDATE selection.
REQ-022 UPDATE SHALL last exactly one cycle with pc_ena=1; pc_next priority: EXC_VEC > jmp_tgt > br_tgt > pc_cur+4.
REQ-023 pc_cur+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-024 On an exception UPDATE, epc SHALL load pc_cur at that edge; otherwise epc holds.
REQ-025 All pending latches SHALL clear on leaving UPDATE.
REQ-026 halt sampled in EXEC SHALL latch; UPDATE then -> HALT instead of FETCH; HALT sticky until reset, pc_ena=0, imem_req=0.
REQ-027 Outside UPDATE, pc_ena=0 and pc_next=pc_cur; in IDLE pc_next=RESET_VEC.
REQ-028 Inputs in IDLE, UPDATE, HALT SHALL be ignored (except clk/rst).

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, all pending latches and targets cleared, epc=0, pc_ena=0, imem_req=0, ir_load=0, imem_addr=0, pc_next=RESET_VEC.
REQ-030 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the instruction with no pc_ena pulse.

Verification
REQ-031 Sequential: pc_cur=0x00400000, ack after 2 cycles, instr_done 3 cycles later -> one pc_ena pulse, pc_next=0x00400004, back to FETCH.
REQ-032 Priority: in EXEC br_taken(0x00400100) then jmp_valid(0x00400200) then exc_req -> UPDATE pc_next=0x00400004, epc=pc_cur.
REQ-033 Misaligned: pc_cur=0x00400002 in FETCH -> imem_req=0, next cycle UPDATE, pc_next=0x00400004, epc=0x00400002.
REQ-034 Stall/wrap: pc_cur=0xFFFFFFFC, instr_done=1 with stall=1 for 4 cycles -> no pc_ena; stall drop -> pc_next=0x00000000.
REQ-035 Halt+reset: halt in EXEC -> one UPDATE then state_o=4 held; rst low mid-EXEC -> state_o=0, pc_next=0x00400000, no pc_ena.
